// File: rtl/i2s_tx.sv
// I2S / left-justified mono DAC serialiser: bclk = clk_50/(2*HALF_DIV), frame = 2*SLOTS bclk periods.
// Outputs are registered with one clk_50 of latency; the input accepts a sample every cycle and never stalls (last write wins).
module i2s_tx #(
  parameter int HALF_DIV = 8,
  parameter int SLOTS    = 32,
  parameter int I2S_MODE = 1
) (
  input  logic        clk_50,
  input  logic        ar,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        underrun_clr,
  output logic        bclk,
  output logic        daclrck,
  output logic        dacdat,
  output logic        sample_req,
  output logic        underrun
);

  localparam logic [7:0] PRESC_LAST = 8'(HALF_DIV - 1);
  localparam logic [6:0] SLOT_LAST  = 7'(2 * SLOTS - 1);
  localparam logic [6:0] SLOTS_W    = 7'(SLOTS);
  localparam logic [6:0] MODE_W     = 7'(I2S_MODE);

  logic [7:0]  r_presc;
  logic        r_bclk;
  logic [6:0]  r_slot;
  logic        r_lrck;
  logic        r_dat;
  logic        r_req;
  logic        r_unr;
  logic [15:0] r_pend;
  logic        r_fresh;
  logic [15:0] r_frame;

  logic        w_tc;
  logic        w_fall;
  logic        w_frame_start;
  logic        w_have_new;
  logic [6:0]  w_slot_nxt;
  logic [6:0]  w_pos;
  logic [6:0]  w_rel;
  logic [3:0]  w_bit_idx;
  logic [15:0] w_frame_nxt;
  logic        w_bit;

  always_comb begin
    w_tc          = (r_presc == PRESC_LAST);
    w_fall        = w_tc && r_bclk;
    w_frame_start = w_fall && (r_slot == SLOT_LAST);
    w_have_new    = sample_valid || r_fresh;
    w_slot_nxt    = (r_slot == SLOT_LAST) ? 7'd0 : r_slot + 7'd1;
    // A sample arriving in the frame-start cycle bypasses the pending register.
    w_frame_nxt   = r_frame;
    if (w_frame_start && w_have_new) begin
      w_frame_nxt = sample_valid ? sample_in : r_pend;
    end
    w_pos     = (w_slot_nxt >= SLOTS_W) ? w_slot_nxt - SLOTS_W : w_slot_nxt;
    w_rel     = w_pos - MODE_W;
    w_bit_idx = 4'd15 - w_rel[3:0];
    w_bit     = 1'b0;
    if ((w_pos >= MODE_W) && (w_rel <= 7'd15)) begin
      w_bit = w_frame_nxt[w_bit_idx];
    end
  end

  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      r_presc <= '0;
      r_bclk  <= 1'b0;
      r_slot  <= '0;
      r_lrck  <= 1'b0;
      r_dat   <= 1'b0;
      r_req   <= 1'b0;
      r_unr   <= 1'b0;
      r_pend  <= '0;
      r_fresh <= 1'b0;
      r_frame <= '0;
    end else begin
      r_req <= w_frame_start;
      if (w_tc) begin
        r_presc <= '0;
        r_bclk  <= ~r_bclk;
      end else begin
        r_presc <= r_presc + 8'd1;
      end
      // Data changes on the bclk fall so the codec samples it on the rise.
      if (w_fall) begin
        r_slot <= w_slot_nxt;
        r_lrck <= (w_slot_nxt >= SLOTS_W);
        r_dat  <= w_bit;
      end
      if (sample_valid) begin
        r_pend <= sample_in;
      end
      if (w_frame_start) begin
        r_frame <= w_frame_nxt;
        r_fresh <= 1'b0;
      end else if (sample_valid) begin
        r_fresh <= 1'b1;
      end
      if (w_frame_start && !w_have_new) begin
        r_unr <= 1'b1;
      end else if (underrun_clr) begin
        r_unr <= 1'b0;
      end
    end
  end

  assign bclk       = r_bclk;
  assign daclrck    = r_lrck;
  assign dacdat     = r_dat;
  assign sample_req = r_req;
  assign underrun   = r_unr;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: one I2S and one left-justified instance share stimulus; a negedge monitor
// decodes each 64-slot frame and tests compare it against expected samples queued at drive time.
module tb_i2s_tx;

  logic        clk_50 = 1'b0;
  logic        ar = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        bclk, daclrck, dacdat, sample_req, underrun;
  logic        lj_bclk, lj_daclrck, lj_dacdat, lj_sample_req, lj_underrun;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [63:0] got_i2s_q[$];
  logic [63:0] got_lj_q[$];
  logic [63:0] got_lrck_q[$];

  localparam logic [63:0] LRCK_EXP = 64'hFFFF_FFFF_0000_0000;

  i2s_tx #(.HALF_DIV(8), .SLOTS(32), .I2S_MODE(1)) dut (
    .clk_50(clk_50), .ar(ar), .sample_in(sample_in), .sample_valid(sample_valid),
    .underrun_clr(underrun_clr), .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat),
    .sample_req(sample_req), .underrun(underrun)
  );

  i2s_tx #(.HALF_DIV(8), .SLOTS(32), .I2S_MODE(0)) dut_lj (
    .clk_50(clk_50), .ar(ar), .sample_in(sample_in), .sample_valid(sample_valid),
    .underrun_clr(underrun_clr), .bclk(lj_bclk), .daclrck(lj_daclrck), .dacdat(lj_dacdat),
    .sample_req(lj_sample_req), .underrun(lj_underrun)
  );

  always #10 clk_50 = ~clk_50;

  initial begin
    #4000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Frame decoder: slot index is bclk rises counted from the sample_req pulse.
  logic [63:0] mon_i2s, mon_lj, mon_lrck;
  int          mon_slot = 0;
  logic        mon_active = 1'b0;
  logic        mon_prev_bclk = 1'b0;

  always @(negedge clk_50) begin
    if (ar) begin
      mon_active = 1'b0;
      mon_slot   = 0;
    end else begin
      if (sample_req) begin
        mon_active = 1'b1;
        mon_slot   = 0;
        mon_i2s    = '0;
        mon_lj     = '0;
        mon_lrck   = '0;
      end
      if (mon_active && bclk && !mon_prev_bclk) begin
        mon_i2s[mon_slot]  = dacdat;
        mon_lj[mon_slot]   = lj_dacdat;
        mon_lrck[mon_slot] = daclrck;
        mon_slot++;
        if (mon_slot == 64) begin
          got_i2s_q.push_back(mon_i2s);
          got_lj_q.push_back(mon_lj);
          got_lrck_q.push_back(mon_lrck);
          mon_active = 1'b0;
        end
      end
    end
    mon_prev_bclk = bclk;
  end

  function automatic logic [63:0] exp_frame(input logic [15:0] v, input int d);
    logic [63:0] f;
    f = '0;
    for (int h = 0; h < 2; h++)
      for (int s = 0; s < 32; s++)
        if (s >= d && s <= 15 + d) f[h*32 + s] = v[15 - (s - d)];
    return f;
  endfunction

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1100 && !ok; i++) begin
      @(negedge clk_50);
      if (sample_req) ok = 1'b1;
    end
    got_i2s_q.delete();
    got_lj_q.delete();
    got_lrck_q.delete();
  endtask

  task automatic get_frame(output bit ok, output logic [63:0] fi, output logic [63:0] fl,
                           output logic [63:0] fr);
    ok = 1'b0;
    fi = '0;
    fl = '0;
    fr = '0;
    for (int i = 0; i < 1100 && !ok; i++) begin
      @(negedge clk_50);
      if (got_i2s_q.size() > 0) begin
        ok = 1'b1;
        fi = got_i2s_q.pop_front();
        fl = got_lj_q.pop_front();
        fr = got_lrck_q.pop_front();
      end
    end
  endtask

  task automatic drive_sample(input logic [15:0] v, input logic clr);
    sample_in    = v;
    sample_valid = 1'b1;
    underrun_clr = clr;
    @(negedge clk_50);
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    bit found;
    logic prev;
    ar = 1'b1;
    repeat (3) @(negedge clk_50);
    checks++; if (bclk !== 1'b0) begin failures++; $display("FAIL rst_bclk got=%b exp=0", bclk); end
    checks++; if (daclrck !== 1'b0) begin failures++; $display("FAIL rst_daclrck got=%b exp=0", daclrck); end
    checks++; if (dacdat !== 1'b0) begin failures++; $display("FAIL rst_dacdat got=%b exp=0", dacdat); end
    checks++; if (sample_req !== 1'b0) begin failures++; $display("FAIL rst_sample_req got=%b exp=0", sample_req); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    ar = 1'b0;
    n = 0; found = 1'b0; prev = bclk;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_50); n++;
      @(negedge clk_50);
      if (prev && !bclk) found = 1'b1;
      prev = bclk;
    end
    checks++; if (!found || n != 16) begin failures++; $display("FAIL first_fall cycle got=%0d exp=16 found=%b", n, found); end
    checks++; if (sample_req !== 1'b0) begin failures++; $display("FAIL first_fall_req got=%b exp=0", sample_req); end
  endtask

  task automatic test_timing;
    int c, last_brise, bper, last_lrise, lper, bad_edge, long_req, lrck_edges;
    logic pb, pl, pr;
    c = 0; last_brise = -1; bper = 0; last_lrise = -1; lper = 0;
    bad_edge = 0; long_req = 0; lrck_edges = 0;
    @(negedge clk_50);
    pb = bclk; pl = daclrck; pr = sample_req;
    for (int i = 0; i < 2600; i++) begin
      @(posedge clk_50); c++;
      @(negedge clk_50);
      if (bclk && !pb) begin
        if (last_brise >= 0) bper = c - last_brise;
        last_brise = c;
      end
      if (daclrck !== pl) begin
        lrck_edges++;
        if (!(pb && !bclk)) bad_edge++;
        if (daclrck) begin
          if (last_lrise >= 0) lper = c - last_lrise;
          last_lrise = c;
        end
      end
      if (sample_req && pr) long_req++;
      pb = bclk; pl = daclrck; pr = sample_req;
    end
    checks++; if (bper != 16) begin failures++; $display("FAIL bclk_period got=%0d exp=16", bper); end
    checks++; if (lper != 1024) begin failures++; $display("FAIL lrck_period got=%0d exp=1024", lper); end
    checks++; if (lrck_edges < 4 || bad_edge != 0) begin failures++; $display("FAIL lrck_on_fall edges=%0d off_fall=%0d exp off_fall=0", lrck_edges, bad_edge); end
    checks++; if (long_req != 0) begin failures++; $display("FAIL req_width multi_cycle=%0d exp=0", long_req); end
  endtask

  task automatic test_pattern(input logic [15:0] first, input logic [15:0] v, input bit two);
    bit ok;
    logic [63:0] fi, fl, fr;
    logic [15:0] e;
    sync_frame(ok);
    checks++; if (!ok) begin failures++; $display("FAIL pat_sync timeout got=0 exp=1"); end
    if (two) begin
      drive_sample(first, 1'b1);
      repeat (5) @(negedge clk_50);
    end
    drive_sample(v, 1'b1);
    exp_q.push_back(v);
    sync_frame(ok);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL pat_underrun %h got=%b exp=0", v, underrun); end
    get_frame(ok, fi, fl, fr);
    e = exp_q.pop_front();
    checks++; if (!ok || fi !== exp_frame(e, 1)) begin failures++; $display("FAIL pat_i2s %h got=%h exp=%h ok=%b", e, fi, exp_frame(e, 1), ok); end
    checks++; if (!ok || fl !== exp_frame(e, 0)) begin failures++; $display("FAIL pat_lj %h got=%h exp=%h ok=%b", e, fl, exp_frame(e, 0), ok); end
    checks++; if (!ok || fr !== LRCK_EXP) begin failures++; $display("FAIL pat_lrck got=%h exp=%h", fr, LRCK_EXP); end
  endtask

  task automatic test_underrun;
    bit ok;
    logic [63:0] fi, fl, fr;
    logic [15:0] e;
    sync_frame(ok);
    drive_sample(16'h1234, 1'b1);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    sync_frame(ok);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ur_fresh got=%b exp=0", underrun); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        sync_frame(ok);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_set miss%0d got=%b exp=1", k, underrun); end
      end
      get_frame(ok, fi, fl, fr);
      e = exp_q.pop_front();
      checks++; if (!ok || fi !== exp_frame(e, 1)) begin failures++; $display("FAIL ur_repeat%0d got=%h exp=%h", k, fi, exp_frame(e, 1)); end
    end
    underrun_clr = 1'b1;
    @(negedge clk_50);
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b exp=0", underrun); end
  endtask

  task automatic test_bypass;
    bit ok;
    logic [63:0] fi, fl, fr;
    logic [15:0] e;
    sync_frame(ok);
    underrun_clr = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    underrun_clr = 1'b0;
    repeat (1022) @(posedge clk_50);
    @(negedge clk_50);
    sample_in    = 16'h7FFF;
    sample_valid = 1'b1;
    exp_q.push_back(16'h7FFF);
    @(negedge clk_50);
    sample_valid = 1'b0;
    got_i2s_q.delete(); got_lj_q.delete(); got_lrck_q.delete();
    checks++; if (sample_req !== 1'b1) begin failures++; $display("FAIL byp_align got=%b exp=1", sample_req); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL byp_underrun got=%b exp=0", underrun); end
    get_frame(ok, fi, fl, fr);
    e = exp_q.pop_front();
    checks++; if (!ok || fi !== exp_frame(e, 1)) begin failures++; $display("FAIL byp_i2s got=%h exp=%h", fi, exp_frame(e, 1)); end
    checks++; if (!ok || fl !== exp_frame(e, 0)) begin failures++; $display("FAIL byp_lj got=%h exp=%h", fl, exp_frame(e, 0)); end
  endtask

  task automatic test_reset_mid;
    bit ok, found;
    int n;
    logic prev;
    logic [63:0] fi, fl, fr;
    logic [15:0] e;
    sync_frame(ok);
    repeat (644) @(posedge clk_50);
    @(negedge clk_50);
    checks++; if (daclrck !== 1'b1) begin failures++; $display("FAIL mid_lrck_right got=%b exp=1", daclrck); end
    #3 ar = 1'b1;
    #1;
    checks++; if ({bclk, daclrck, dacdat, sample_req, underrun} !== 5'b0) begin failures++; $display("FAIL mid_async_clear got=%b exp=00000", {bclk, daclrck, dacdat, sample_req, underrun}); end
    repeat (2) @(negedge clk_50);
    ar = 1'b0;
    n = 0; found = 1'b0; prev = bclk;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_50); n++;
      @(negedge clk_50);
      if (prev && !bclk) found = 1'b1;
      prev = bclk;
    end
    checks++; if (!found || n != 16) begin failures++; $display("FAIL mid_first_fall got=%0d exp=16", n); end
    exp_q.push_back(16'h0000);
    sync_frame(ok);
    checks++; if (!ok || underrun !== 1'b1) begin failures++; $display("FAIL mid_underrun got=%b exp=1 ok=%b", underrun, ok); end
    get_frame(ok, fi, fl, fr);
    e = exp_q.pop_front();
    checks++; if (!ok || fi !== exp_frame(e, 1) || fl !== exp_frame(e, 0)) begin failures++; $display("FAIL mid_zero_frame i2s=%h lj=%h exp=0", fi, fl); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pattern(16'h0000, 16'hA5C3, 1'b0);
    test_pattern(16'h1111, 16'h8001, 1'b1);
    test_underrun();
    test_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
